traffic_ctrl_n: RTL



---
 rtl/traffic_ctrl_n.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/traffic_ctrl_n.sv
// N-way round-robin traffic light controller with counter-timed GREEN/YELLOW/ALLRED phases.
// Optional pedestrian WALK phase compiled in with `define TRAFFIC_PED_EN.
module traffic_ctrl_n #(
    parameter int N_WAYS    = 2,
    parameter int CNT_W     = 8,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 6,
    localparam int AW       = (N_WAYS > 1) ? $clog2(N_WAYS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_WAYS-1:0]   sensor,
`ifdef TRAFFIC_PED_EN
    input  logic                ped_req,
    output logic                walk,
`endif
    output logic [2*N_WAYS-1:0] lights,
    output logic [AW-1:0]       active_way,
    output logic [1:0]          phase
);

    // State encoding doubles as the phase output, so phase is the FSM state itself.
    localparam logic [1:0] ST_GREEN  = 2'b00;
    localparam logic [1:0] ST_YELLOW = 2'b01;
    localparam logic [1:0] ST_ALLRED = 2'b10;
`ifdef TRAFFIC_PED_EN
    localparam logic [1:0] ST_WALK   = 2'b11;
    localparam logic [CNT_W-1:0] WALK_END = CNT_W'(WALK_T - 1);
`endif

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] GMIN_END = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_END = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_END  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ARED_END = CNT_W'(ALLRED_T - 1);
    localparam logic [AW-1:0]    LAST_WAY = AW'(N_WAYS - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    way_q, way_d;

    logic [AW-1:0]     next_way;
    logic [AW-1:0]     scan;
    logic              found;
    logic [N_WAYS-1:0] cur_mask;
    logic              other_dem;
    logic              green_exit;

`ifdef TRAFFIC_PED_EN
    logic ped_pend_q, ped_pend_d;
`else
    logic walk_t_unused;
    assign walk_t_unused = (WALK_T != 0);
`endif

    // Round-robin search: first requesting way after the current one, else simply the next one.
    always_comb begin
        scan     = way_q;
        found    = 1'b0;
        next_way = (way_q == LAST_WAY) ? '0 : way_q + 1'b1;
        for (int i = 0; i < N_WAYS; i++) begin
            scan = (scan == LAST_WAY) ? '0 : scan + 1'b1;
            if (!found && sensor[scan]) begin
                found    = 1'b1;
                next_way = scan;
            end
        end
    end

    always_comb begin
        cur_mask  = N_WAYS'(1) << way_q;
        other_dem = |(sensor & ~cur_mask);
`ifdef TRAFFIC_PED_EN
        other_dem = other_dem | ped_pend_q;
`endif
        green_exit = (cnt_q >= GMIN_END) && other_dem
                     && (!sensor[way_q] || (cnt_q >= GMAX_END));
    end

    always_comb begin
        state_d = state_q;
        way_d   = way_q;
        case (state_q)
            ST_GREEN: begin
                if (green_exit) state_d = ST_YELLOW;
            end
            ST_YELLOW: begin
                if (cnt_q == YEL_END) state_d = ST_ALLRED;
            end
            ST_ALLRED: begin
                if (cnt_q == ARED_END) begin
`ifdef TRAFFIC_PED_EN
                    if (ped_pend_q) begin
                        state_d = ST_WALK;
                    end else begin
                        state_d = ST_GREEN;
                        way_d   = next_way;
                    end
`else
                    state_d = ST_GREEN;
                    way_d   = next_way;
`endif
                end
            end
`ifdef TRAFFIC_PED_EN
            ST_WALK: begin
                if (cnt_q == WALK_END) begin
                    state_d = ST_GREEN;
                    way_d   = next_way;
                end
            end
`endif
            default: state_d = ST_ALLRED;
        endcase
    end

    // Every state entry is a state change, so a change restarts the phase counter.
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

`ifdef TRAFFIC_PED_EN
    always_comb begin
        if (state_d == ST_WALK && state_q != ST_WALK) begin
            ped_pend_d = 1'b0;
        end else begin
            ped_pend_d = ped_pend_q | ped_req;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ALLRED;
            cnt_q   <= '0;
            way_q   <= LAST_WAY;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            way_q   <= way_d;
        end
    end

`ifdef TRAFFIC_PED_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ped_pend_q <= 1'b0;
        end else begin
            ped_pend_q <= ped_pend_d;
        end
    end

    assign walk = (state_q == ST_WALK);
`endif

    // Only the served way can be non-red, and only in GREEN or YELLOW.
    always_comb begin
        for (int k = 0; k < N_WAYS; k++) begin
            lights[2*k +: 2] = 2'b10;
            if (way_q == AW'(k)) begin
                if (state_q == ST_GREEN) begin
                    lights[2*k +: 2] = 2'b00;
                end else if (state_q == ST_YELLOW) begin
                    lights[2*k +: 2] = 2'b01;
                end
            end
        end
    end

    assign phase      = state_q;
    assign active_way = way_q;

endmodule
